// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with one-outstanding imem request and skid buffer
// Optional IF_TIMEOUT_EN: imem_ack watchdog driving a sticky fetch_err.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction,
    output logic        valid,
    output logic        fetch_err
);

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]  state;
    logic [31:0] fetch_pc;
    logic [31:0] redirect_pc;
    logic [31:0] pc_plus4;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        out_free;
    logic        ack_fire;
    logic        capture;
    logic        timeout;

    assign pc_plus4  = fetch_pc + 32'd4;
    assign out_free  = !valid || !freeze;
    assign imem_addr = fetch_pc;
    assign ack_fire  = imem_req && imem_ack;
    // DISCARD consumes the ack of a request made obsolete by a branch.
    assign capture   = ack_fire && (state != ST_DISCARD);

    always_comb begin
        imem_req = 1'b0;
        if (rst) begin
            case (state)
                ST_FETCH:   imem_req = !skid_valid && !(valid && freeze);
                ST_WAIT:    imem_req = 1'b1;
                ST_DISCARD: imem_req = 1'b1;
                default:    imem_req = 1'b0;
            endcase
        end
    end

`ifdef IF_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    assign timeout = (state != ST_FETCH) && !imem_ack
                     && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst || state == ST_FETCH || imem_ack || timeout) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_err <= 1'b0;
        end else if (timeout) begin
            fetch_err <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout            = 1'b0;
    assign fetch_err          = 1'b0;
`endif

    // Request side: PC, redirect target and request state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_FETCH;
            fetch_pc    <= RESET_PC;
            redirect_pc <= RESET_PC;
        end else if (branch_taken) begin
            if (imem_req && !imem_ack) begin
                redirect_pc <= branch_addr;
                state       <= ST_DISCARD;
            end else begin
                fetch_pc <= branch_addr;
                state    <= ST_FETCH;
            end
        end else if (timeout) begin
            state <= ST_FETCH;
            if (state == ST_DISCARD) begin
                fetch_pc <= redirect_pc;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    if (capture) begin
                        fetch_pc <= pc_plus4;
                    end else if (imem_req) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (capture) begin
                        fetch_pc <= pc_plus4;
                        state    <= ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    if (ack_fire) begin
                        fetch_pc <= redirect_pc;
                        state    <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

    // Output side: IF/ID register and the one-entry skid buffer behind it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_out      <= '0;
            instruction <= '0;
            valid       <= 1'b0;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
        end else if (branch_taken) begin
            valid       <= 1'b0;
            instruction <= '0;
            skid_valid  <= 1'b0;
        end else if (capture) begin
            if (out_free) begin
                instruction <= imem_rdata;
                pc_out      <= pc_plus4;
                valid       <= 1'b1;
            end else begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc_plus4;
                skid_valid <= 1'b1;
            end
        end else if (!freeze) begin
            if (skid_valid) begin
                instruction <= skid_instr;
                pc_out      <= skid_pc;
                valid       <= 1'b1;
                skid_valid  <= 1'b0;
            end else begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage feeding the IF/ID register, which in turn feeds the decode stage.
- Holds the PC and issues one-outstanding-request fetches on a req/ack instruction-memory port.
- Presents {pc_out, instruction, valid} downstream, with freeze from the hazard unit and branch redirect from EXE.
- A one-entry skid buffer absorbs a fetch that returns while the output is frozen.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, max wait cycles for imem_ack; used only with IF_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low; rst=0 resets at the clock edge
- freeze  in  1  hazard stall: hold output register
- branch_taken  in  1  redirect request from EXE
- branch_addr  in  32  redirect target
- imem_req  out  1  fetch request; combinational from state/flags
- imem_addr  out  32  fetch address, equal to fetch_pc
- imem_ack  in  1  request accepted, data valid this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- pc_out  out  32  fetch address of the instruction + 4
- instruction  out  32  fetched instruction word
- valid  out  1  instruction/pc_out hold a live instruction
- fetch_err  out  1  sticky timeout flag; constant 0 without IF_TIMEOUT_EN

Behaviour:
- Reset (rst=0 at an edge):
  - fetch_pc=RESET_PC, pc_out=0, instruction=0, valid=0.
  - Skid buffer empty, state=FETCH, fetch_err=0.
  - imem_req is 0 while rst=0.
- Memory protocol:
  - Once imem_req=1, imem_addr is held stable until an edge with imem_ack=1.
  - Zero-wait ack in the same cycle is legal, which gives a throughput of 1 instruction per cycle.
- States:
  - FETCH: imem_req = !skid_valid && !(valid && freeze).
  - WAIT: imem_req=1. Entered from FETCH when req=1 and ack=0.
  - DISCARD: imem_req=1 with the old address, and the returning data is dropped.
- Transitions:
  - WAIT→FETCH on ack.
  - DISCARD→FETCH on ack, loading fetch_pc=redirect_pc.
- Data capture on an ack edge (not discarded):
  - If output is free (!valid || !freeze): instruction<=imem_rdata, pc_out<=fetch_pc+4, valid<=1.
  - Otherwise the word goes into the skid buffer (skid_instr, skid_pc = fetch_pc+4), skid_valid<=1.
  - In both cases fetch_pc<=fetch_pc+4.
- Output advance with no new capture:
  - If !freeze and skid_valid: output<=skid, skid_valid<=0.
  - If !freeze and no skid: valid<=0.
  - The skid buffer always drains before new data reaches the output (program order).
- freeze=1 with valid=1: instruction, pc_out and valid hold exactly.
- freeze=1 with valid=0: capture is allowed.
- Branch (branch_taken=1), highest priority over freeze and capture:
  - valid<=0, instruction<=0, skid_valid<=0.
  - If a request is pending without ack this cycle (req=1, ack=0): redirect_pc<=branch_addr, state<=DISCARD.
  - Otherwise: fetch_pc<=branch_addr, state<=FETCH. Data acked in the same cycle is dropped.
- Branch while in DISCARD: redirect_pc is overwritten with the newest branch_addr.
- PC arithmetic: modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0. Low two bits are not forced.
- Reset mid-request: the request is abandoned and imem_req drops in the reset cycle. The memory must tolerate this.

Optional Feature:
- Macro: IF_TIMEOUT_EN.
- Defined:
  - A wait counter runs in WAIT/DISCARD and clears on ack.
  - When it reaches TIMEOUT_CYCLES without an ack: fetch_err<=1 (sticky until reset), the request is abandoned, state→FETCH, and fetch_pc is unchanged (or set to redirect_pc if in DISCARD).
- Not defined:
  - No counter; fetch_err is tied to 0.
  - The stage waits indefinitely for imem_ack.

Test Plan:
- Reset then zero-wait memory returning word = addr|32'hE000_0000 → valid=1 from the 2nd cycle after reset release, pc_out sequence 4, 8, 12, instruction 32'hE000_0000, E000_0004.
- Two-cycle-latency memory → one instruction per 3 cycles, valid pulses, pc_out 4, 8, 12, no skipped address.
- freeze=1 for 3 cycles while the output holds pc_out=8 and a request is in WAIT with ack arriving mid-freeze → output holds 8, skid captures pc 12. After freeze drops, outputs 12 then 16, with no new req while skid_valid=1.
- branch_taken=1, branch_addr=32'h100 while a request to 0x10 is pending with ack after 2 more cycles → valid=0 next cycle, DISCARD keeps imem_addr=0x10 until ack, next req addr=0x100, pc_out=0x104.
- branch_taken and freeze together with valid=1 and skid full → valid=0, skid cleared, next fetch from branch_addr.
- IF_TIMEOUT_EN with TIMEOUT_CYCLES=4 and ack never asserted → fetch_err=1 after 4 wait cycles, stays 1, and the request is reissued at the same address.
